// File: rtl/zif_cycle_sequencer.sv
// rtl/zif_cycle_sequencer.sv - cycle-exact setup/strobe/hold sequencer for one ZIF bus access
// All pin outputs are registered from the next-state decode so they change exactly on phase edges.
module zif_cycle_sequencer #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              osc,
   input  logic              rst,
   input  logic              cmd_valid,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [CNT_W-1:0]  t_setup,
   input  logic [CNT_W-1:0]  t_pulse,
   input  logic [CNT_W-1:0]  t_hold,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   input  logic [DATA_W-1:0] zif_data_in,
   output logic [ADDR_W-1:0] zif_addr,
   output logic [DATA_W-1:0] zif_data_out,
   output logic              zif_data_oe,
   output logic              zif_ce_n,
   output logic              zif_oe_n,
   output logic              zif_we_n
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_PULSE = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               r_write;
   logic [CNT_W-1:0]   r_t_pulse;
   logic [CNT_W-1:0]   r_t_hold;
   logic               w_accept;
   logic               w_cnt_zero;
   logic               w_write_nxt;
   logic               w_active_nxt;

   // A zero timing value still yields a one-cycle phase.
   function automatic logic [CNT_W-1:0] f_load(input logic [CNT_W-1:0] t);
      return (t == '0) ? '0 : t - CNT_W'(1);
   endfunction

   assign w_accept     = (r_state == S_IDLE) && cmd_valid;
   assign w_cnt_zero   = (r_cnt == '0);
   assign w_write_nxt  = w_accept ? cmd_write : r_write;
   assign w_active_nxt = (w_state_nxt != S_IDLE);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               w_state_nxt = S_SETUP;
               w_cnt_nxt   = f_load(t_setup);
            end
         end
         S_SETUP: begin
            if (w_cnt_zero) begin
               w_state_nxt = S_PULSE;
               w_cnt_nxt   = f_load(r_t_pulse);
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         S_PULSE: begin
            if (w_cnt_zero) begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = f_load(r_t_hold);
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         S_HOLD: begin
            if (w_cnt_zero) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge osc) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_write      <= 1'b0;
         r_t_pulse    <= '0;
         r_t_hold     <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         rdata        <= '0;
         zif_addr     <= '0;
         zif_data_out <= '0;
         zif_data_oe  <= 1'b0;
         zif_ce_n     <= 1'b1;
         zif_oe_n     <= 1'b1;
         zif_we_n     <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_write   <= cmd_write;
            r_t_pulse <= t_pulse;
            r_t_hold  <= t_hold;
            zif_addr  <= cmd_addr;
            if (cmd_write) begin
               zif_data_out <= cmd_wdata;
            end
         end
         // Sample the bus at the close of the final strobe cycle.
         if ((r_state == S_PULSE) && w_cnt_zero && !r_write) begin
            rdata <= zif_data_in;
         end
         busy        <= w_active_nxt;
         done        <= (r_state == S_HOLD) && (w_state_nxt == S_IDLE);
         zif_ce_n    <= !w_active_nxt;
         zif_data_oe <= w_active_nxt && w_write_nxt;
         zif_oe_n    <= !((w_state_nxt == S_PULSE) && !w_write_nxt);
         zif_we_n    <= !((w_state_nxt == S_PULSE) && w_write_nxt);
      end
   end

endmodule

// File: tb/tb_zif_cycle_sequencer.sv
// tb/tb_zif_cycle_sequencer.sv - directed and randomized checks of zif_cycle_sequencer against a phase-timeline model
module tb_zif_cycle_sequencer;

   logic        osc = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_write;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_wdata;
   logic [15:0] t_setup;
   logic [15:0] t_pulse;
   logic [15:0] t_hold;
   logic        busy;
   logic        done;
   logic [7:0]  rdata;
   logic [7:0]  zif_data_in;
   logic [15:0] zif_addr;
   logic [7:0]  zif_data_out;
   logic        zif_data_oe;
   logic        zif_ce_n;
   logic        zif_oe_n;
   logic        zif_we_n;

   int vectors     = 0;
   int miscompares = 0;

   logic [15:0] exp_addr;
   logic [7:0]  exp_dout;
   logic [7:0]  exp_rdata;

   logic        nx_w;
   logic [15:0] nx_a;
   logic [7:0]  nx_d;
   logic [15:0] nx_ts, nx_tp, nx_th;

   logic        c_w;
   logic [15:0] c_a;
   logic [7:0]  c_d;
   logic [15:0] c_ts, c_tp, c_th;

   zif_cycle_sequencer #(.ADDR_W(16), .DATA_W(8), .CNT_W(16)) dut (
      .osc          (osc),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_write    (cmd_write),
      .cmd_addr     (cmd_addr),
      .cmd_wdata    (cmd_wdata),
      .t_setup      (t_setup),
      .t_pulse      (t_pulse),
      .t_hold       (t_hold),
      .busy         (busy),
      .done         (done),
      .rdata        (rdata),
      .zif_data_in  (zif_data_in),
      .zif_addr     (zif_addr),
      .zif_data_out (zif_data_out),
      .zif_data_oe  (zif_data_oe),
      .zif_ce_n     (zif_ce_n),
      .zif_oe_n     (zif_oe_n),
      .zif_we_n     (zif_we_n)
   );

   always #5 osc = ~osc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   task automatic apply(input logic w, input logic [15:0] a, input logic [7:0] d,
                        input logic [15:0] ts, input logic [15:0] tp, input logic [15:0] th);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      t_setup   = ts;
      t_pulse   = tp;
      t_hold    = th;
   endtask

   task automatic idle_check(input string tag);
      chk({tag, " busy"},  busy,         0);
      chk({tag, " done"},  done,         0);
      chk({tag, " ce_n"},  zif_ce_n,     1);
      chk({tag, " oe_n"},  zif_oe_n,     1);
      chk({tag, " we_n"},  zif_we_n,     1);
      chk({tag, " dataoe"}, zif_data_oe, 0);
      chk({tag, " addr"},  zif_addr,     exp_addr);
      chk({tag, " dout"},  zif_data_out, exp_dout);
      chk({tag, " rdata"}, rdata,        exp_rdata);
   endtask

   // Expected pins come from where cycle k falls in the setup/pulse/hold timeline.
   task automatic run(input logic w, input logic [15:0] a, input logic [7:0] d,
                      input logic [15:0] ts, input logic [15:0] tp, input logic [15:0] th,
                      input logic [7:0] din, input logic hold);
      int ms, mp, mh, len, ph;
      ms  = (ts == 0) ? 1 : int'(ts);
      mp  = (tp == 0) ? 1 : int'(tp);
      mh  = (th == 0) ? 1 : int'(th);
      len = ms + mp + mh;
      @(posedge osc);
      exp_addr = a;
      if (w) exp_dout = d;
      for (int k = 0; k < len; k++) begin
         @(negedge osc);
         ph = (k < ms) ? 1 : ((k < ms + mp) ? 2 : 3);
         chk("cyc busy",   busy,         1);
         chk("cyc done",   done,         0);
         chk("cyc ce_n",   zif_ce_n,     0);
         chk("cyc addr",   zif_addr,     exp_addr);
         chk("cyc dataoe", zif_data_oe,  w);
         chk("cyc dout",   zif_data_out, exp_dout);
         chk("cyc oe_n",   zif_oe_n,     !((ph == 2) && !w));
         chk("cyc we_n",   zif_we_n,     !((ph == 2) && w));
         chk("cyc rdata",  rdata,        (!w && (k >= ms + mp)) ? din : exp_rdata);
         zif_data_in = (k == ms + mp - 1) ? din : 8'($urandom);
         if (k == 0) begin
            if (hold) begin
               nx_w  = 1'($urandom);
               nx_a  = 16'($urandom);
               nx_d  = 8'($urandom);
               nx_ts = 16'($urandom_range(0, 4));
               nx_tp = 16'($urandom_range(0, 4));
               nx_th = 16'($urandom_range(0, 4));
               apply(nx_w, nx_a, nx_d, nx_ts, nx_tp, nx_th);
            end else begin
               apply(1'($urandom), 16'($urandom), 8'($urandom), 16'($urandom),
                     16'($urandom), 16'($urandom));
               cmd_valid = 1'b0;
            end
         end
      end
      if (!w) exp_rdata = din;
      @(negedge osc);
      chk("end done",   done,         1);
      chk("end busy",   busy,         0);
      chk("end ce_n",   zif_ce_n,     1);
      chk("end oe_n",   zif_oe_n,     1);
      chk("end we_n",   zif_we_n,     1);
      chk("end dataoe", zif_data_oe,  0);
      chk("end addr",   zif_addr,     exp_addr);
      chk("end dout",   zif_data_out, exp_dout);
      chk("end rdata",  rdata,        exp_rdata);
   endtask

   initial begin
      logic hold;
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      t_setup = '0; t_pulse = '0; t_hold = '0; zif_data_in = '0;
      exp_addr = '0; exp_dout = '0; exp_rdata = '0;

      repeat (2) @(posedge osc);
      @(negedge osc);
      idle_check("reset");
      rst = 1'b0;
      @(negedge osc);
      idle_check("post reset");

      apply(1'b0, 16'h1234, 8'h00, 16'd2, 16'd3, 16'd1);
      run(1'b0, 16'h1234, 8'h00, 16'd2, 16'd3, 16'd1, 8'hA5, 1'b0);
      chk("read rdata", rdata, 8'hA5);
      @(negedge osc);
      idle_check("after read");

      apply(1'b1, 16'h00FF, 8'h3C, 16'd1, 16'd4, 16'd2);
      run(1'b1, 16'h00FF, 8'h3C, 16'd1, 16'd4, 16'd2, 8'h5A, 1'b0);
      @(negedge osc);
      idle_check("after write");

      apply(1'b0, 16'hBEEF, 8'h00, 16'd0, 16'd0, 16'd0);
      run(1'b0, 16'hBEEF, 8'h00, 16'd0, 16'd0, 16'd0, 8'h77, 1'b1);
      run(nx_w, nx_a, nx_d, nx_ts, nx_tp, nx_th, 8'($urandom), 1'b0);

      apply(1'b0, 16'h0A0A, 8'h00, 16'd1, 16'd2, 16'd1);
      run(1'b0, 16'h0A0A, 8'h00, 16'd1, 16'd2, 16'd1, 8'h11, 1'b0);
      chk("b2b first", rdata, 8'h11);
      apply(1'b0, 16'h0B0B, 8'h00, 16'd2, 16'd1, 16'd2);
      run(1'b0, 16'h0B0B, 8'h00, 16'd2, 16'd1, 16'd2, 8'h22, 1'b0);
      chk("b2b second", rdata, 8'h22);

      apply(1'b1, 16'h4321, 8'hC3, 16'd1, 16'd4, 16'd2);
      @(posedge osc);
      @(negedge osc);
      cmd_valid = 1'b0;
      chk("abort setup ce_n", zif_ce_n, 0);
      @(negedge osc);
      @(negedge osc);
      chk("abort pulse we_n", zif_we_n, 0);
      chk("abort pulse busy", busy, 1);
      chk("abort pulse rdata", rdata, 8'h22);
      rst = 1'b1;
      @(negedge osc);
      exp_addr = '0; exp_dout = '0; exp_rdata = '0;
      idle_check("abort reset");
      rst = 1'b0;
      repeat (4) begin
         @(negedge osc);
         idle_check("abort idle");
      end

      c_w = 1'($urandom); c_a = 16'($urandom); c_d = 8'($urandom);
      c_ts = 16'($urandom_range(0, 4)); c_tp = 16'($urandom_range(0, 4));
      c_th = 16'($urandom_range(0, 4));
      apply(c_w, c_a, c_d, c_ts, c_tp, c_th);
      for (int i = 0; i < 24; i++) begin
         hold = ($urandom_range(0, 3) == 0);
         run(c_w, c_a, c_d, c_ts, c_tp, c_th, 8'($urandom), hold);
         if (hold) begin
            c_w = nx_w; c_a = nx_a; c_d = nx_d;
            c_ts = nx_ts; c_tp = nx_tp; c_th = nx_th;
         end else begin
            if ($urandom_range(0, 1) == 1) begin
               @(negedge osc);
               idle_check("rand idle");
            end
            c_w = 1'($urandom); c_a = 16'($urandom); c_d = 8'($urandom);
            c_ts = 16'($urandom_range(0, 4)); c_tp = 16'($urandom_range(0, 4));
            c_th = 16'($urandom_range(0, 4));
            apply(c_w, c_a, c_d, c_ts, c_tp, c_th);
         end
      end
      run(c_w, c_a, c_d, c_ts, c_tp, c_th, 8'($urandom), 1'b0);

      apply(1'b0, 16'hFACE, 8'h00, 16'd0, 16'hFFFF, 16'd0);
      run(1'b0, 16'hFACE, 8'h00, 16'd0, 16'hFFFF, 16'd0, 8'h96, 1'b0);
      @(negedge osc);
      idle_check("final idle");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/zif_cycle_sequencer.md
Name: zif_cycle_sequencer

Overview:
- Sequences one parallel-bus access cycle (read or write) on the ZIF socket pins of a chip under test.
- Setup, strobe and hold phases have programmable lengths, counted in cycles of the 24MHz oscillator clock.
- Sits between the microcontroller register interface (bulk read/write at address 8'h10) and the ZIF pin buffers.
- Replaces the ad-hoc delay_count handling in each bottomhalf with one reusable, cycle-exact engine.

Parameters:
- ADDR_W, 16, width of the chip-under-test address bus.
- DATA_W, 8, width of the chip-under-test data bus.
- CNT_W, 16, width of the phase timing fields and the internal down-counter.

Ports:
- osc  input  1  24MHz clock, post-IBUF; the only clock.
- rst  input  1  synchronous reset, active-high.
- cmd_valid  input  1  start request, sampled every osc edge.
- cmd_write  input  1  1=write cycle, 0=read cycle.
- cmd_addr  input  ADDR_W  target address.
- cmd_wdata  input  DATA_W  write data.
- t_setup  input  CNT_W  setup phase length, in cycles.
- t_pulse  input  CNT_W  strobe phase length, in cycles.
- t_hold  input  CNT_W  hold phase length, in cycles.
- busy  output  1  high while a cycle is in progress.
- done  output  1  one-cycle pulse when a cycle completes.
- rdata  output  DATA_W  last captured read data.
- zif_data_in  input  DATA_W  data bus as sampled from the ZIF pins.
- zif_addr  output  ADDR_W  address to the ZIF pins.
- zif_data_out  output  DATA_W  write data to the ZIF pins.
- zif_data_oe  output  1  1=FPGA drives the data pins.
- zif_ce_n  output  1  chip enable, active low.
- zif_oe_n  output  1  output enable, active low.
- zif_we_n  output  1  write enable, active low.

Behaviour:
- Reset, applied on the next edge regardless of state:
  - state=IDLE.
  - busy=0, done=0.
  - rdata=0, zif_addr=0, zif_data_out=0, zif_data_oe=0.
  - zif_ce_n=zif_oe_n=zif_we_n=1.
  - Reset mid-cycle aborts the cycle: strobes deassert and the data bus is released on that edge, and no done pulse is produced.
- All outputs are registered.
- States: IDLE -> SETUP -> PULSE -> HOLD -> IDLE.
- Command acceptance:
  - A command is accepted only in IDLE with cmd_valid=1.
  - On acceptance, latch cmd_write, cmd_addr, cmd_wdata, t_setup, t_pulse and t_hold; later changes to these inputs have no effect on the running cycle.
  - cmd_valid while busy=1 is ignored, not queued.
- Phase length is max(t,1) cycles; a timing value of 0 is treated as 1.
  - The counter loads max(t,1)-1 on phase entry.
  - The phase advances when the counter is 0; otherwise the counter decrements.
- Pin values by state:
  - IDLE: ce_n=oe_n=we_n=1, data_oe=0; zif_addr and zif_data_out hold their last values.
  - SETUP: ce_n=0, zif_addr=latched addr; write: data_oe=1, zif_data_out=wdata; oe_n=we_n=1.
  - PULSE: as SETUP, plus read: oe_n=0; write: we_n=0.
  - HOLD: oe_n=we_n=1; ce_n, addr, data and data_oe unchanged from PULSE.
- Read capture: rdata <= zif_data_in on the edge that leaves PULSE, i.e. the last PULSE cycle. rdata is unchanged by write cycles.
- Timing, for a command accepted on edge E0:
  - busy=1 from E0 through the end of the last HOLD cycle.
  - Total busy duration = max(ts,1)+max(tp,1)+max(th,1) cycles.
  - On the edge leaving HOLD: busy=0 and done=1 for exactly one cycle.
- Back-to-back: cmd_valid=1 in the done cycle is accepted (state is IDLE), so there is no dead cycle between accesses.
  - The IDLE pin values still apply for that done cycle: strobes inactive, ce_n=1.
- Counter arithmetic is unsigned CNT_W and never underflows. t=2^CNT_W-1 gives the maximum phase length.

Test Plan:
- Reset: assert rst for 2 cycles mid-idle -> busy=0, done=0, rdata=0, ce_n/oe_n/we_n=1, data_oe=0.
- Read, ts=2 tp=3 th=1, addr=16'h1234, zif_data_in=8'hA5 -> busy high exactly 6 cycles; zif_addr=16'h1234; oe_n low exactly 3 cycles; we_n stays 1; data_oe stays 0; done pulses once; rdata=8'hA5.
- Write, ts=1 tp=4 th=2, addr=16'h00FF, wdata=8'h3C -> data_oe=1 and zif_data_out=8'h3C for all 7 busy cycles; we_n low exactly 4 cycles starting cycle 2; oe_n stays 1; rdata unchanged.
- Zero timings, ts=tp=th=0 read -> busy 3 cycles with one cycle each of SETUP/PULSE/HOLD. Then cmd_valid held high with new inputs during busy -> second command not started until the done cycle; inputs changed mid-cycle do not alter pins.
- Reset in the 2nd PULSE cycle of a write -> next edge we_n=1, ce_n=1, data_oe=0, busy=0, no done pulse; rdata keeps its pre-reset value until the reset edge, then 0.
- Back-to-back reads (8'h11 then 8'h22), cmd_valid asserted in the done cycle -> second busy starts the edge after done with no gap; rdata=8'h11 after the first done and 8'h22 after the second.
